// File: rtl/pixel_fetcher.sv
// pixel_fetcher: fetches one video line of RGB444 words from pixel memory
// into a first-word-fall-through FIFO, with credit-based request throttling.
//
// Ports:
//   buffer_clock, reset         clock (rising edge), async active-high reset
//   frame_start, line_request   control pulses (rewind/abort, fetch a line)
//   mem_read, mem_address       memory request, held stable while stalled
//   mem_ready                   memory accepts the request this cycle
//   mem_valid, mem_data         in-order read responses (RGB444 in [11:0])
//   pixel_valid, pixel_data     FIFO head towards the line-buffer writer
//   pixel_ready                 downstream consumes the head pixel
//   busy, line_done             not idle; last response of a line received
//   underrun_count              only with PIXEL_FETCHER_UNDERRUN_EN defined
module pixel_fetcher #(
  parameter int LINE_PIXELS = 640,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_WIDTH  = 22
) (
  input  logic                  buffer_clock,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  line_request,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic                  mem_ready,
  input  logic                  mem_valid,
  input  logic [15:0]           mem_data,
  output logic                  pixel_valid,
  output logic [11:0]           pixel_data,
  input  logic                  pixel_ready,
  output logic                  busy,
  output logic                  line_done
`ifdef PIXEL_FETCHER_UNDERRUN_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(LINE_PIXELS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FLUSH
  } state_t;

  state_t state;
  state_t state_next;

  logic [IW-1:0] issued;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [11:0]   fifo_mem [FIFO_DEPTH];

  logic accept;
  logic resp;
  logic push;
  logic pop;
  logic last_issue;
  logic unused_hi;

  assign unused_hi = ^mem_data[15:12];

  // Requests in flight plus stored pixels never exceed the FIFO size,
  // so every response always has a free slot waiting for it.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};

  assign mem_read = (state == FETCH)
                 && (issued < IW'(LINE_PIXELS))
                 && (credit_used < (CW+1)'(FIFO_DEPTH));

  assign accept     = mem_read && mem_ready;
  // A response with nothing tracked in flight is stale (e.g. across reset).
  assign resp       = mem_valid && (outstanding != '0);
  assign out_next   = outstanding + CW'(accept) - CW'(resp);
  assign last_issue = accept && (issued == IW'(LINE_PIXELS - 1));

  assign push = resp && (state != FLUSH) && !frame_start;
  assign pop  = pixel_valid && pixel_ready;

  assign pixel_valid = (fifo_count != '0);
  assign pixel_data  = pixel_valid ? fifo_mem[rd_ptr] : 12'h000;
  assign busy        = (state != IDLE);

  always_comb begin
    state_next = state;
    line_done  = 1'b0;
    case (state)
      IDLE: begin
        if (line_request) state_next = FETCH;
      end
      FETCH: begin
        if (frame_start)
          state_next = (out_next != '0) ? FLUSH : IDLE;
        else if (last_issue)
          state_next = DRAIN;
      end
      DRAIN: begin
        if (frame_start) begin
          state_next = (out_next != '0) ? FLUSH : IDLE;
        end else if (out_next == '0) begin
          state_next = IDLE;
          line_done  = 1'b1;
        end
      end
      FLUSH: begin
        if (out_next == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge buffer_clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      issued      <= '0;
      outstanding <= '0;
      mem_address <= '0;
    end else begin
      state       <= state_next;
      outstanding <= out_next;
      if (state == IDLE && line_request)
        issued <= '0;
      else if (accept)
        issued <= issued + 1'b1;
      // Rewind wins over an accept in the same cycle.
      if (frame_start)
        mem_address <= '0;
      else if (accept)
        mem_address <= mem_address + 1'b1;
    end
  end

  always_ff @(posedge buffer_clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (frame_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge buffer_clock) begin
    if (push) fifo_mem[wr_ptr] <= mem_data[11:0];
  end

`ifdef PIXEL_FETCHER_UNDERRUN_EN
  always_ff @(posedge buffer_clock or posedge reset) begin
    if (reset)
      underrun_count <= '0;
    else if (frame_start)
      underrun_count <= '0;
    else if (busy && pixel_ready && !pixel_valid
             && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pixel_fetcher.sv
// tb_pixel_fetcher: directed bench for pixel_fetcher with a latency and
// ready-pattern configurable memory model and a pixel sink.
module tb_pixel_fetcher;

  localparam int LP = 640;
  localparam int FD = 16;
  localparam int AW = 10;

  logic          buffer_clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          line_request = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_valid = 1'b0;
  logic [15:0]   mem_data = 16'hDEAD;
  logic          pixel_ready = 1'b0;
  logic          mem_read;
  logic [AW-1:0] mem_address;
  logic          pixel_valid;
  logic [11:0]   pixel_data;
  logic          busy;
  logic          line_done;
`ifdef PIXEL_FETCHER_UNDERRUN_EN
  logic [15:0]   underrun_count;
`endif

  pixel_fetcher #(
    .LINE_PIXELS (LP),
    .FIFO_DEPTH  (FD),
    .ADDR_WIDTH  (AW)
  ) dut (
    .buffer_clock (buffer_clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .line_request (line_request),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_ready    (mem_ready),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .pixel_valid  (pixel_valid),
    .pixel_data   (pixel_data),
    .pixel_ready  (pixel_ready),
    .busy         (busy),
`ifdef PIXEL_FETCHER_UNDERRUN_EN
    .underrun_count (underrun_count),
`endif
    .line_done    (line_done)
  );

  always #5 buffer_clock = ~buffer_clock;

  typedef struct {
    int addr;
    int due;
  } req_t;

  req_t        pend[$];
  logic [11:0] got[$];
  int checks = 0;
  int failures = 0;
  int lat = 1;
  int ready_mode = 0;
  int cyc = 0;
  int ld_cnt = 0;
  int acc_cnt = 0;
  int resp_cnt = 0;
  int stall_err = 0;
  int max_out = 0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  function automatic logic [11:0] pix(int a);
    int v;
    v = (a % 1024) * 7 + 3;
    return v[11:0];
  endfunction

  // Memory model and pixel sink: drive at negedge, sample 1 unit later.
  always @(negedge buffer_clock) begin
    cyc++;
    if (reset) begin
      pend.delete();
      mem_valid  = 1'b0;
      mem_ready  = 1'b0;
      mem_data   = 16'hDEAD;
      prev_stall = 1'b0;
    end else begin
      mem_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? (cyc % 2 == 0) : 1'b0;
      mem_valid = 1'b0;
      mem_data  = 16'hDEAD;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        mem_valid = 1'b1;
        mem_data  = {4'hC, pix(pend[0].addr)};
        void'(pend.pop_front());
        resp_cnt++;
      end
      #1;
      if (prev_stall && !(mem_read && mem_address == prev_addr))
        stall_err++;
      prev_stall = mem_read && !mem_ready && !frame_start;
      prev_addr  = mem_address;
      if (mem_read && mem_ready) begin
        pend.push_back('{int'(mem_address), cyc + lat});
        acc_cnt++;
      end
      if (pend.size() > max_out) max_out = pend.size();
      if (pixel_valid && pixel_ready) got.push_back(pixel_data);
      if (line_done) ld_cnt++;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_lr();
    line_request = 1'b1;
    @(negedge buffer_clock);
    line_request = 1'b0;
  endtask

  task automatic wait_idle(int n_pix, int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge buffer_clock);
      if (!busy && got.size() >= n_pix) break;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_line(string tag, int base, int n);
    int nbad = 0;
    chk({tag, "_count"}, got.size(), n);
    for (int i = 0; i < got.size() && i < n; i++)
      if (got[i] !== pix(base + i)) nbad++;
    chk({tag, "_data"}, nbad, 0);
  endtask

  initial begin
    int n0;
    int rc0;

    repeat (3) @(negedge buffer_clock);
    #2;
    chk("rst_mem_read", {31'd0, mem_read}, 0);
    chk("rst_mem_address", {22'd0, mem_address}, 0);
    chk("rst_pixel_valid", {31'd0, pixel_valid}, 0);
    chk("rst_pixel_data", {20'd0, pixel_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_line_done", {31'd0, line_done}, 0);
`ifdef PIXEL_FETCHER_UNDERRUN_EN
    chk("rst_underrun", {16'd0, underrun_count}, 0);
`endif
    @(negedge buffer_clock);
    reset = 1'b0;
    @(negedge buffer_clock);

    // Basic line: latency 1, always ready, sink always ready.
    lat = 1; ready_mode = 0; pixel_ready = 1'b1;
    got.delete(); ld_cnt = 0;
    pulse_lr();
    chk("l1_busy", {31'd0, busy}, 1);
    wait_idle(LP, 2000);
    check_line("l1", 0, LP);
    chk("l1_line_done", ld_cnt, 1);
    chk("l1_addr", {22'd0, mem_address}, 640);
    chk("l1_pix_valid", {31'd0, pixel_valid}, 0);

    // Back-pressure: sink stalled, credit limits accepts to FIFO depth.
    pixel_ready = 1'b0;
    got.delete(); ld_cnt = 0; acc_cnt = 0;
    pulse_lr();
    repeat (60) @(negedge buffer_clock);
    pulse_lr();
    repeat (40) @(negedge buffer_clock);
    #2;
    chk("bp_accepts", acc_cnt, FD);
    chk("bp_mem_read", {31'd0, mem_read}, 0);
    chk("bp_pix_valid", {31'd0, pixel_valid}, 1);
    chk("bp_pix_data", {20'd0, pixel_data}, {20'd0, pix(640)});
    chk("bp_busy", {31'd0, busy}, 1);
    @(negedge buffer_clock);
    pixel_ready = 1'b1;
    wait_idle(LP, 3000);
    check_line("bp", 640, LP);
    chk("bp_total_accepts", acc_cnt, LP);
    chk("bp_addr_wrap", {22'd0, mem_address}, 256);
    chk("bp_line_done", ld_cnt, 1);
    repeat (5) @(negedge buffer_clock);
    chk("bp_req_ignored", {31'd0, busy}, 0);

    // Toggling mem_ready, latency 3.
    lat = 3; ready_mode = 1;
    got.delete(); ld_cnt = 0; stall_err = 0; max_out = 0;
    pulse_lr();
    wait_idle(LP, 4000);
    check_line("tg", 256, LP);
    chk("tg_addr", {22'd0, mem_address}, 896);
    chk("tg_stable", stall_err, 0);
    chk("tg_max_out", {31'd0, max_out <= FD}, 1);
    chk("tg_line_done", ld_cnt, 1);

    // Abort with reads in flight.
    lat = 4; ready_mode = 0;
    got.delete(); ld_cnt = 0;
    pulse_lr();
    for (int i = 0; i < 1000; i++) begin
      if (got.size() >= 300) break;
      @(negedge buffer_clock);
    end
    frame_start = 1'b1;
    #2;
    rc0 = resp_cnt;
    n0  = got.size();
    @(negedge buffer_clock);
    frame_start = 1'b0;
    #2;
    chk("fs_mem_read", {31'd0, mem_read}, 0);
    chk("fs_busy_flush", {31'd0, busy}, 1);
    chk("fs_addr", {22'd0, mem_address}, 0);
    chk("fs_pix_valid", {31'd0, pixel_valid}, 0);
    wait_idle(0, 100);
    chk("fs_discarded", resp_cnt - rc0, 4);
    chk("fs_no_pixels", got.size(), n0);
    chk("fs_no_line_done", ld_cnt, 0);
    check_line("fs_prefix", 896, n0);

    lat = 1;
    got.delete(); ld_cnt = 0;
    pulse_lr();
    wait_idle(LP, 2000);
    check_line("after_fs", 0, LP);
    chk("after_fs_addr", {22'd0, mem_address}, 640);

    // Rewind and request in the same idle cycle.
    got.delete(); ld_cnt = 0;
    frame_start = 1'b1;
    line_request = 1'b1;
    @(negedge buffer_clock);
    frame_start = 1'b0;
    line_request = 1'b0;
    wait_idle(LP, 2000);
    check_line("fs_lr", 0, LP);
    chk("fs_lr_addr", {22'd0, mem_address}, 640);
    chk("fs_lr_line_done", ld_cnt, 1);

    // Reset in the middle of a line.
    lat = 3;
    got.delete();
    pulse_lr();
    repeat (50) @(negedge buffer_clock);
    reset = 1'b1;
    repeat (3) @(negedge buffer_clock);
    #2;
    chk("mrst_mem_read", {31'd0, mem_read}, 0);
    chk("mrst_busy", {31'd0, busy}, 0);
    chk("mrst_addr", {22'd0, mem_address}, 0);
    chk("mrst_pix_valid", {31'd0, pixel_valid}, 0);
    chk("mrst_pix_data", {20'd0, pixel_data}, 0);
    @(negedge buffer_clock);
    reset = 1'b0;
    @(negedge buffer_clock);
    got.delete(); ld_cnt = 0;
    pulse_lr();
    wait_idle(LP, 3000);
    check_line("mrst_line", 0, LP);
    chk("mrst_line_done", ld_cnt, 1);

`ifdef PIXEL_FETCHER_UNDERRUN_EN
    frame_start = 1'b1;
    @(negedge buffer_clock);
    frame_start = 1'b0;
    lat = 19;
    got.delete();
    pulse_lr();
    for (int i = 0; i < 100; i++) begin
      if (got.size() >= 1) break;
      @(negedge buffer_clock);
    end
    chk("ur_count", {16'd0, underrun_count}, 20);
    frame_start = 1'b1;
    @(negedge buffer_clock);
    frame_start = 1'b0;
    #2;
    chk("ur_cleared", {16'd0, underrun_count}, 0);
    wait_idle(0, 200);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_fetcher.md
PIXEL_FETCHER -- requirements
Module: pixel_fetcher

Interface
REQ-001 SHALL have parameter LINE_PIXELS, default 640, pixels fetched per line request.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two, 4..64).
REQ-003 SHALL have parameter ADDR_WIDTH, default 22, memory word address width.
REQ-004 SHALL have port buffer_clock  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port frame_start  in  1  one-cycle pulse; rewind address to 0 and abort any line.
REQ-007 SHALL have port line_request  in  1  one-cycle pulse; fetch next LINE_PIXELS words.
REQ-008 SHALL have port mem_read  out  1  read request to pixel memory.
REQ-009 SHALL have port mem_address  out  ADDR_WIDTH  word address of the request.
REQ-010 SHALL have port mem_ready  in  1  memory accepts request this cycle.
REQ-011 SHALL have port mem_valid  in  1  read data returned, in request order.
REQ-012 SHALL have port mem_data  in  16  returned word; bits [11:0] are RGB444, [15:12] ignored.
REQ-013 SHALL have port pixel_valid  out  1  pixel_data holds a pixel.
REQ-014 SHALL have port pixel_data  out  12  RGB444 pixel, head of FIFO.
REQ-015 SHALL have port pixel_ready  in  1  downstream line-buffer writer consumes the pixel.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-017 SHALL have port line_done  out  1  one-cycle pulse when last response of a line is received.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, FLUSH.
REQ-019 IDLE -> FETCH on line_request; issued count cleared to 0.
REQ-020 In FETCH, mem_read SHALL be high iff issued < LINE_PIXELS and outstanding + fifo_count < FIFO_DEPTH.
REQ-021 A request SHALL be accepted on mem_read && mem_ready; then mem_address += 1 and issued += 1 next cycle; mem_address and mem_read SHALL hold stable while mem_ready is low.
REQ-022 mem_address SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-023 FETCH -> DRAIN on the cycle issued reaches LINE_PIXELS; DRAIN -> IDLE when outstanding reaches 0, with line_done pulsed that cycle.
REQ-024 Every mem_valid outside FLUSH SHALL write mem_data[11:0] into the FIFO; credit rule (REQ-020) guarantees no overflow; simultaneous write and read SHALL leave fifo_count unchanged.
REQ-025 pixel_valid SHALL equal fifo_count != 0; pop on pixel_valid && pixel_ready; read path zero latency (first-word-fall-through).
REQ-026 line_request outside IDLE SHALL be ignored.
REQ-027 frame_start in any state SHALL set mem_address to 0, clear FIFO, deassert mem_read next cycle; if outstanding != 0 go FLUSH, else IDLE; no line_done.
REQ-028 FLUSH SHALL discard mem_valid data and go IDLE when outstanding reaches 0.
REQ-029 frame_start and line_request in the same IDLE cycle: rewind first, then FETCH from address 0.
REQ-030 outstanding counter SHALL increment on accept, decrement on mem_valid, unchanged when both occur.

Reset
REQ-031 On reset: state IDLE, mem_read 0, mem_address 0, issued 0, outstanding 0, FIFO empty, pixel_valid 0, pixel_data 0, busy 0, line_done 0.
REQ-032 Reset mid-line SHALL take effect immediately; responses arriving after deassertion SHALL be discarded until outstanding (tracked as 0) — memory side is reset by the same signal.

Configuration
REQ-033 Macro PIXEL_FETCHER_UNDERRUN_EN defined: add output underrun_count (16 bits, reset 0, saturating) incremented each cycle busy && pixel_ready && !pixel_valid; cleared by frame_start.
REQ-034 Macro undefined: underrun_count port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-035 Reset, line_request, mem_ready=1, mem_valid one cycle after each accept, pixel_ready=1 -> 640 pixels equal to mem_data[11:0] of addresses 0..639, line_done once, mem_address=640.
REQ-036 pixel_ready=0 whole line, memory always ready -> exactly 16 accepts, mem_read low, pixel_valid=1; raise pixel_ready -> fetch resumes, no data lost or reordered.
REQ-037 mem_ready toggling 50%, mem_valid latency 3 cycles -> mem_address stable while stalled, 640 in-order pixels, outstanding never exceeds 16.
REQ-038 frame_start at pixel 300 with 4 reads outstanding -> FLUSH, 4 responses discarded, no line_done, next line_request fetches from address 0.
REQ-039 line_request while busy, and at mem_address 0x3FFFFF -> ignored; address wraps to 0x000000.
REQ-040 With PIXEL_FETCHER_UNDERRUN_EN, memory valid delayed 20 cycles, pixel_ready=1 -> underrun_count=20 at first pixel; frame_start -> 0.
